// File: rtl/isa_pkg.sv
// Shared definitions for the sequential ISA datapath.
//   - ALU opcode encodings and an opcode validity helper
//   - FSM state encoding
//   - instruction field offsets, derived from IMM_W and AW
// Instruction layout, MSB to LSB: A[IMM_W] B[IMM_W] mode[1] op[3] addr[AW] we[1]
package isa_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_GT  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_LEER     = 2'b01,
    S_OPERAR   = 2'b10,
    S_ENTREGAR = 2'b11
  } state_t;

  // Field offsets (LSB position of each field).
  localparam int OFF_WE   = 0;
  localparam int OFF_ADDR = 1;

  function automatic int off_op(input int aw);
    return aw + 1;
  endfunction

  function automatic int off_mode(input int aw);
    return aw + 4;
  endfunction

  function automatic int off_b(input int aw);
    return aw + 5;
  endfunction

  function automatic int off_a(input int imm_w, input int aw);
    return aw + 5 + imm_w;
  endfunction

  function automatic int inst_width(input int imm_w, input int aw);
    return 2 * imm_w + aw + 5;
  endfunction

  // True for the five implemented opcodes.
  function automatic logic op_is_valid(input logic [2:0] op);
    logic ok;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_GT: ok = 1'b1;
      default:                              ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_param.sv
// Combinational ALU, DW bits wide. Operands are unsigned; unimplemented
// opcodes produce a zero result and raise the invalid-opcode flag.
module alu_param
  import isa_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    op,
  output logic [DW-1:0] result,
  output logic          acarreo,
  output logic          op_invalida
);

  logic [DW:0] sum_s;

  assign sum_s = {1'b0, a} + {1'b0, b};

  // Opcode decode and result/flag selection.
  always_comb begin
    result      = {DW{1'b0}};
    acarreo     = 1'b0;
    op_invalida = 1'b0;
    case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_ADD: begin
        result  = sum_s[DW-1:0];
        acarreo = sum_s[DW];
      end
      OP_SUB: begin
        result  = a - b;
        acarreo = (a < b);
      end
      OP_GT: begin
        if (a > b) begin
          result = {{(DW-1){1'b0}}, 1'b1};
        end else begin
          result = {DW{1'b0}};
        end
      end
      default: op_invalida = 1'b1;
    endcase
  end

endmodule

// File: rtl/isa_secuencial.sv
// Multi-cycle ISA datapath: accepts one instruction per inst_valid/inst_ready
// handshake, optionally reads a data RAM, runs the ALU, optionally writes the
// result back, and presents result + flags on a salida_valid/salida_ready channel.
module isa_secuencial
  import isa_pkg::*;
#(
  parameter  int IMM_W  = 5,
  parameter  int DW     = 32,
  parameter  int AW     = 5,
  localparam int INST_W = 2 * IMM_W + AW + 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [INST_W-1:0] instruccion,
  output logic [DW-1:0]     salida,
  output logic              salida_valid,
  input  logic              salida_ready,
  output logic              acarreo,
  output logic              cero,
  output logic              op_invalida
);

  localparam int DEPTH    = 2 ** AW;
  localparam int OFF_OP   = off_op(AW);
  localparam int OFF_MODE = off_mode(AW);
  localparam int OFF_B    = off_b(AW);
  localparam int OFF_A    = off_a(IMM_W, AW);

  state_t            state_q, state_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [DW-1:0]     rd_data_q, rd_data_d;
  logic [DW-1:0]     salida_q, salida_d;
  logic              salida_valid_q, salida_valid_d;
  logic              acarreo_q, acarreo_d;
  logic              cero_q, cero_d;
  logic              op_inv_q, op_inv_d;
  logic [DW-1:0]     ram_q [DEPTH];

  // Decoded fields of the latched instruction.
  logic [IMM_W-1:0]  a_imm_s, b_imm_s;
  logic              mode_s, we_s;
  logic [2:0]        op_s;
  logic [AW-1:0]     addr_s;
  // Fields of the incoming instruction needed for the IDLE branch.
  logic              in_mode_s, in_we_s;

  logic [DW-1:0]     ram_rd_s;
  logic              ram_we_s;
  logic [DW-1:0]     alu_a_s, alu_b_s, alu_res_s;
  logic              alu_c_s, alu_inv_s;

  assign a_imm_s   = inst_q[OFF_A +: IMM_W];
  assign b_imm_s   = inst_q[OFF_B +: IMM_W];
  assign mode_s    = inst_q[OFF_MODE];
  assign op_s      = inst_q[OFF_OP +: 3];
  assign addr_s    = inst_q[OFF_ADDR +: AW];
  assign we_s      = inst_q[OFF_WE];
  assign in_mode_s = instruccion[OFF_MODE];
  assign in_we_s   = instruccion[OFF_WE];

  // RAM word at the latched address; only consumed through registers at the
  // LEER edge, so the read behaves as a synchronous read.
  assign ram_rd_s = ram_q[addr_s];

  // Operand A comes from RAM (read in LEER) in mode 1, else the immediate.
  assign alu_a_s = mode_s ? rd_data_q : {{(DW-IMM_W){1'b0}}, a_imm_s};
  assign alu_b_s = {{(DW-IMM_W){1'b0}}, b_imm_s};

  alu_param #(.DW(DW)) u_alu (
    .a           (alu_a_s),
    .b           (alu_b_s),
    .op          (op_s),
    .result      (alu_res_s),
    .acarreo     (alu_c_s),
    .op_invalida (alu_inv_s)
  );

  // Next-state, datapath register and RAM-write decode.
  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    rd_data_d = rd_data_q;
    salida_d  = salida_q;
    acarreo_d = acarreo_q;
    cero_d    = cero_q;
    op_inv_d  = op_inv_q;
    ram_we_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (inst_valid) begin
          inst_d = instruccion;
          // mode only matters for writes; every read-only goes through LEER.
          if (!in_we_s || in_mode_s) begin
            state_d = S_LEER;
          end else begin
            state_d = S_OPERAR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LEER: begin
        rd_data_d = ram_rd_s;
        if (!we_s) begin
          salida_d  = ram_rd_s;
          acarreo_d = 1'b0;
          op_inv_d  = 1'b0;
          cero_d    = (ram_rd_s == {DW{1'b0}});
          state_d   = S_ENTREGAR;
        end else begin
          state_d = S_OPERAR;
        end
      end
      S_OPERAR: begin
        salida_d  = alu_res_s;
        acarreo_d = alu_c_s;
        op_inv_d  = alu_inv_s;
        cero_d    = (alu_res_s == {DW{1'b0}});
        ram_we_s  = we_s && !alu_inv_s;
        state_d   = S_ENTREGAR;
      end
      S_ENTREGAR: begin
        if (salida_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ENTREGAR;
        end
      end
      default: state_d = S_IDLE;
    endcase
    salida_valid_d = (state_d == S_ENTREGAR);
  end

  // FSM and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      inst_q         <= {INST_W{1'b0}};
      rd_data_q      <= {DW{1'b0}};
      salida_q       <= {DW{1'b0}};
      salida_valid_q <= 1'b0;
      acarreo_q      <= 1'b0;
      cero_q         <= 1'b0;
      op_inv_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      inst_q         <= inst_d;
      rd_data_q      <= rd_data_d;
      salida_q       <= salida_d;
      salida_valid_q <= salida_valid_d;
      acarreo_q      <= acarreo_d;
      cero_q         <= cero_d;
      op_inv_q       <= op_inv_d;
    end
  end

  // Data RAM: cleared by reset, which also blocks any write at that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ram_q[i] <= {DW{1'b0}};
      end
    end else if (ram_we_s) begin
      ram_q[addr_s] <= alu_res_s;
    end else begin
      ram_q[addr_s] <= ram_q[addr_s];
    end
  end

  // inst_ready is forced low while rst is held so no instruction is taken
  // during reset; it rises in the first cycle after reset.
  assign inst_ready   = (state_q == S_IDLE) && !rst;
  assign salida       = salida_q;
  assign salida_valid = salida_valid_q;
  assign acarreo      = acarreo_q;
  assign cero         = cero_q;
  assign op_invalida  = op_inv_q;

endmodule

// File: tb/tb_isa_secuencial.sv
module tb_isa_secuencial;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic        inst_ready;
  logic [19:0] instruccion;
  logic [31:0] salida;
  logic        salida_valid;
  logic        salida_ready;
  logic        acarreo;
  logic        cero;
  logic        op_invalida;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected DUT outputs for the current cycle, maintained by the driver.
  logic        chk_en    = 1'b0;
  logic        exp_ready = 1'b0;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_out   = 32'd0;
  logic        exp_c     = 1'b0;
  logic        exp_z     = 1'b0;
  logic        exp_inv   = 1'b0;

  // Behavioural memory image.
  logic [31:0] mram [32];

  isa_secuencial dut (
    .clk          (clk),
    .rst          (rst),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .instruccion  (instruccion),
    .salida       (salida),
    .salida_valid (salida_valid),
    .salida_ready (salida_ready),
    .acarreo      (acarreo),
    .cero         (cero),
    .op_invalida  (op_invalida)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("inst_ready", {31'd0, inst_ready}, {31'd0, exp_ready});
      chk("salida_valid", {31'd0, salida_valid}, {31'd0, exp_valid});
      chk("salida", salida, exp_out);
      chk("acarreo", {31'd0, acarreo}, {31'd0, exp_c});
      chk("cero", {31'd0, cero}, {31'd0, exp_z});
      chk("op_invalida", {31'd0, op_invalida}, {31'd0, exp_inv});
    end
  end

  // Reference model: executes one instruction against mram from the rules.
  task automatic model_exec(input logic [19:0] inst, output int lat,
                            output logic [31:0] res, output logic c,
                            output logic inv);
    int unsigned a, b, mode, op, addr, we, opa;
    longint unsigned s;
    a    = (inst >> 15) & 31;
    b    = (inst >> 10) & 31;
    mode = (inst >> 9) & 1;
    op   = (inst >> 6) & 7;
    addr = (inst >> 1) & 31;
    we   = inst & 1;
    c    = 1'b0;
    inv  = 1'b0;
    res  = 32'd0;
    if (we == 0) begin
      lat = 2;
      res = mram[addr];
    end else begin
      lat = (mode != 0) ? 3 : 2;
      opa = (mode != 0) ? mram[addr] : a;
      case (op)
        0: res = opa & b;
        1: res = opa | b;
        2: begin
          s   = longint'(opa) + longint'(b);
          res = s[31:0];
          c   = s[32];
        end
        6: begin
          res = opa - b;
          c   = (opa < b);
        end
        7: res = (opa > b) ? 32'd1 : 32'd0;
        default: inv = 1'b1;
      endcase
      if (!inv) mram[addr] = res;
    end
  endtask

  // Issue one instruction, hold the result for 'hold' cycles, then consume it.
  task automatic run_inst(input logic [19:0] inst, input int hold,
                          input logic pin_en, input logic [31:0] pin_val,
                          input logic pin_c);
    int lat;
    logic [31:0] res;
    logic c, inv;
    model_exec(inst, lat, res, c, inv);
    instruccion = inst;
    inst_valid  = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      inst_valid = 1'($urandom_range(0, 1));
      exp_ready  = 1'b0;
      if (k == lat) begin
        exp_valid = 1'b1;
        exp_out   = res;
        exp_c     = c;
        exp_z     = (res == 32'd0);
        exp_inv   = inv;
        if (pin_en) begin
          chk("pin_salida", salida, pin_val);
          chk("pin_acarreo", {31'd0, acarreo}, {31'd0, pin_c});
        end
      end
    end
    for (int h = 0; h < hold; h++) begin
      salida_ready = 1'b0;
      inst_valid   = 1'($urandom_range(0, 1));
      instruccion  = 20'($urandom);
      @(posedge clk); #1;
    end
    salida_ready = 1'b1;
    @(posedge clk); #1;
    salida_ready = 1'b0;
    inst_valid   = 1'b0;
    exp_ready    = 1'b1;
    exp_valid    = 1'b0;
  endtask

  initial begin
    logic [19:0] ri;
    int lat;
    logic [31:0] res;
    logic c, inv;

    for (int i = 0; i < 32; i++) mram[i] = 32'd0;
    rst          = 1'b1;
    inst_valid   = 1'b0;
    instruccion  = 20'd0;
    salida_ready = 1'b0;
    @(posedge clk); #1;
    chk_en    = 1'b1;
    exp_ready = 1'b0;
    @(posedge clk); #1;
    rst       = 1'b0;
    exp_ready = 1'b1;
    @(posedge clk); #1;

    // Directed sequence.
    run_inst(20'b00010_00111_0_010_00011_1, 0, 1'b1, 32'd9, 1'b0);
    run_inst(20'b00000_00000_0_000_00011_0, 0, 1'b1, 32'd9, 1'b0);
    run_inst(20'b00100_11000_0_110_11110_1, 0, 1'b1, 32'hFFFFFFEC, 1'b1);
    run_inst(20'b10000_11101_0_111_00111_1, 0, 1'b1, 32'd0, 1'b0);
    run_inst(20'b11101_10000_0_111_01000_1, 0, 1'b1, 32'd1, 1'b0);
    run_inst(20'b00000_00111_1_010_00011_1, 5, 1'b1, 32'd16, 1'b0);
    run_inst(20'b00000_00000_0_000_00011_0, 0, 1'b1, 32'd16, 1'b0);
    run_inst(20'b00001_00001_0_011_00101_1, 0, 1'b1, 32'd0, 1'b0);
    run_inst(20'b00000_00000_0_000_00101_0, 0, 1'b1, 32'd0, 1'b0);
    run_inst(20'b11111_11111_0_010_00110_1, 2, 1'b1, 32'd62, 1'b0);

    // Reset while an immediate ADD to addr 5 is in OPERAR.
    instruccion = 20'b00011_00100_0_010_00101_1;
    inst_valid  = 1'b1;
    @(posedge clk); #1;
    inst_valid = 1'b0;
    rst        = 1'b1;
    exp_ready  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mram[i] = 32'd0;
    exp_ready = 1'b1;
    exp_valid = 1'b0;
    exp_out   = 32'd0;
    exp_c     = 1'b0;
    exp_z     = 1'b0;
    exp_inv   = 1'b0;
    @(posedge clk); #1;
    run_inst(20'b00000_00000_0_000_00101_0, 0, 1'b1, 32'd0, 1'b0);
    run_inst(20'b00000_00000_0_000_00110_0, 0, 1'b1, 32'd0, 1'b0);

    // Pin the model itself on a few hand-computed cases.
    model_exec(20'b11111_00001_0_010_00000_0, lat, res, c, inv);
    chk("model_read", res, 32'd0);
    model_exec(20'b00001_00010_0_110_01111_1, lat, res, c, inv);
    chk("model_sub", res, 32'hFFFFFFFF);
    chk("model_borrow", {31'd0, c}, 32'd1);
    model_exec(20'b00000_00011_1_010_01111_1, lat, res, c, inv);
    chk("model_m1add", res, 32'd2);
    chk("model_carry", {31'd0, c}, 32'd1);
    chk("model_lat", lat, 32'd3);
    // Bring the DUT's RAM in line with those model-side writes.
    run_inst(20'b00001_00010_0_110_01111_1, 0, 1'b0, 32'd0, 1'b0);
    mram[15] = 32'hFFFFFFFF;
    run_inst(20'b00000_00011_1_010_01111_1, 0, 1'b1, 32'd2, 1'b1);
    mram[15] = 32'd2;

    // Randomized traffic over a small address window to exercise reuse.
    for (int n = 0; n < 200; n++) begin
      ri      = 20'($urandom);
      ri[5:1] = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) ri[0] = 1'b0;
      run_inst(ri, $urandom_range(0, 3), 1'b0, 32'd0, 1'b0);
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/isa_secuencial.md
Name: isa_secuencial

Overview:
- Multi-cycle, parametrised successor of the combinational ISA datapath.
- Accepts one instruction per valid/ready handshake and decodes it into two immediate operands, a mode bit, a 3-bit ALU opcode, a RAM address and a write-enable.
- Executes through an FSM with a synchronous-read data RAM, and returns the result plus flags on a valid/ready output channel.
- Sits between the instruction source (testbench or future fetch unit) and the result consumer.

Parameters:
- IMM_W, 5, width of each immediate operand field.
- DW, 32, datapath and RAM word width.
- AW, 5, RAM address width; depth is 2**AW.
- INST_W, 2*IMM_W+AW+5, instruction width; 20 at defaults. Derived; never overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- inst_valid  in  1  instruction offered.
- inst_ready  out  1  block idle and able to accept.
- instruccion  in  INST_W  fields MSB to LSB: A[IMM_W], B[IMM_W], mode[1], op[3], addr[AW], we[1].
- salida  out  DW  result word.
- salida_valid  out  1  result available.
- salida_ready  in  1  consumer accepts result.
- acarreo  out  1  ADD carry-out / SUB borrow.
- cero  out  1  salida == 0.
- op_invalida  out  1  opcode is not implemented.

Behaviour:
- Reset: one clock; reset is synchronous and active-high (rst sampled on clk rising edge).
  - On reset: state IDLE; salida, salida_valid, acarreo, cero, op_invalida all 0; inst_ready 0 while rst=1, 1 on the first cycle after.
  - All RAM words are cleared to 0.
- Operands are A and B zero-extended to DW.
- ALU opcodes:
  - 000 AND, 001 OR, 010 ADD, 110 SUB (A-B mod 2**DW), 111 GT (unsigned A>B gives 1, else 0).
  - 011, 100, 101 are invalid.
- Flags:
  - acarreo is bit DW of the ADD sum, or the borrow (A<B) for SUB; 0 for all other ops.
- FSM states:
  - IDLE: inst_ready=1. On inst_valid, latch the instruction. Go to LEER if we=0 or mode=1, else go to OPERAR.
  - LEER: present addr to RAM; registered read data is available in the next state. If we=0, go to ENTREGAR with salida=RAM[addr] and flags 0 (cero computed). If we=1, go to OPERAR.
  - OPERAR: operand A is RAM data when mode=1, else the immediate A.
    - Register the ALU result and flags.
    - If we=1 and op is valid, write RAM[addr]=result at this edge.
    - Invalid op: salida=0, op_invalida=1, no RAM write.
    - Go to ENTREGAR.
  - ENTREGAR: salida_valid=1. Outputs stay stable until salida_ready=1. On that edge go to IDLE and drop salida_valid. salida keeps its last value.
- Latency (accept edge to first salida_valid cycle):
  - Immediate write: 2 cycles.
  - Read-only: 2 cycles.
  - mode=1 write: 3 cycles.
- inst_ready is 0 in every state except IDLE; inst_valid outside IDLE is ignored.
- Read-after-write: the next instruction reads the value written, because the write completes before IDLE.
- rst asserted in any state aborts: no RAM write occurs at that edge, RAM is cleared, and the pending result is discarded.
- mode is ignored when we=0.

Decomposition:
- isa_pkg holds:
  - opcode localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_GT);
  - FSM state encoding;
  - field-offset constants derived from IMM_W and AW.
- One natural sub-module: alu_param, combinational, DW-parametrised. Inputs a, b, op; outputs result, acarreo, op_invalida.
- RAM and FSM stay in the top module.

Test Plan:
- Reset, then 00010_00111_0_010_00011_1 -> salida=9, acarreo=0, valid 2 cycles after accept; RAM[3]=9.
- Next, 00000_00000_0_000_00011_0 -> salida=9 after 2 cycles; RAM unchanged.
- SUB 00100_11000_0_110_11110_1 -> salida=0xFFFFFFEC, acarreo=1; then GT 16>29 -> 0, cero=1; GT 29>16 -> 1.
- With RAM[3]=9, mode=1 ADD 00000_00111_1_010_00011_1 -> salida=16 after 3 cycles; RAM[3]=16.
- Backpressure: hold salida_ready=0 for 5 cycles while toggling inst_valid -> salida stable, inst_ready=0, no new instruction accepted; release -> inst_ready=1 next cycle.
- Invalid op 00001_00001_0_011_00101_1 -> salida=0, op_invalida=1, RAM[5] reads 0.
- Reset mid-op: rst pulsed in OPERAR for an ADD to addr 5 -> RAM[5] reads 0, salida_valid never asserted.
